multiplier_seq: RTL and testbench
=================================

// Module: multiplier_seq
// PURPOSE
//  Limb-serial multi-precision unsigned multiplier with valid/ready handshakes; successor to the combinational multiplier.
//  Computes M = A*B, or A*A in square mode, over NUM_ELEMENTS WORD_LEN-bit limbs.
//  Uses one limb-row of multipliers per cycle plus a sequential carry-normalise pass.
//  Returns a fully normalised packed product, so no redundant carry bits are left for the consumer.
// PARAMETERS
//  NUM_ELEMENTS  17  limbs per operand (>=2)
//  WORD_LEN      16  bits per limb
//  ACC_LEN       2*WORD_LEN+$clog2(NUM_ELEMENTS)+1  accumulator column width (derived, localparam)
// PORTS
//  clk        in   1                            clock, rising edge
//  rst_n      in   1                            asynchronous, active-low reset
//  in_valid   in   1                            operands valid
//  in_ready   out  1                            block can accept operands
//  sq_i       in   1                            1: square mode, M=A*A, b_i ignored
//  a_i        in   NUM_ELEMENTS*WORD_LEN        operand A, limb i at [WORD_LEN*(i+1)-1 : WORD_LEN*i]
//  b_i        in   NUM_ELEMENTS*WORD_LEN        operand B, same packing
//  out_valid  out  1                            product valid
//  out_ready  in   1                            consumer accepts product
//  m_o        out  2*NUM_ELEMENTS*WORD_LEN      normalised product, limb j at [WORD_LEN*(j+1)-1 : WORD_LEN*j]
//  busy_o     out  1                            high in MUL or NORM
// BEHAVIOUR
//  - Reset, async on rst_n=0: state=IDLE, in_ready=1, out_valid=0, busy_o=0, m_o=0, accumulator=0, counters=0.
//  - FSM states: IDLE -> MUL -> NORM -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid&&in_ready at cycle T:
//    - latch A into a_q; latch B into b_q (or A if sq_i=1).
//    - clear all 2*NUM_ELEMENTS accumulator columns; k=0; go to MUL.
//  - MUL, cycles T+1..T+NUM_ELEMENTS:
//    - acc[k+i] += a_q[i]*b_q[k] for all i; k++.
//    - Leave when k reaches NUM_ELEMENTS-1.
//  - NORM, cycles T+NUM_ELEMENTS+1..T+3*NUM_ELEMENTS:
//    - ripple one column per cycle, j=0..2N-1.
//    - m_q[j] = (acc[j]+carry)[WORD_LEN-1:0]; carry = (acc[j]+carry)>>WORD_LEN.
//    - carry is ACC_LEN-WORD_LEN bits wide and is zero after the final column. Assert this in simulation.
//  - DONE: out_valid=1 from cycle T+3*NUM_ELEMENTS+1; latency is 3*NUM_ELEMENTS+1 cycles from handshake.
//    - m_o is stable while out_valid && !out_ready.
//    - On out_ready, go to IDLE; out_valid drops the next cycle.
//  - in_ready is high only in IDLE. in_valid in any other state is ignored and never queued.
//  - Inputs are sampled only on handshake; a_i/b_i/sq_i may change freely afterwards.
//  - Column widths: a column sums at most NUM_ELEMENTS products < 2^(2*WORD_LEN), so ACC_LEN never overflows.
//  - Operand edge cases: A=0 or B=0 yields m_o=0 with the same latency. No early exit, so latency is data-independent.
//  - Reset mid-operation aborts immediately. The next accepted operation is unaffected by any stale accumulator content.
// STRUCTURE
//  - Package multiplier_pkg holds:
//    - mul_state_t enum {IDLE,MUL,NORM,DONE};
//    - function acc_len(n,w) returning 2*w+$clog2(n)+1;
//    - limb packing helpers shared with the combinational multiplier bench.
//  - Sub-module multiplier_row (combinational, parameters NUM_ELEMENTS/WORD_LEN):
//    - inputs: A limbs and one B limb;
//    - output: NUM_ELEMENTS partial products of 2*WORD_LEN bits each.
//  - Top level holds the FSM, counters, accumulator columns, normaliser and output register.
// TESTING
//  1. rst_n=0 mid-run -> in_ready=1, out_valid=0, m_o=0, busy_o=0 that same cycle, no clock needed.
//  2. A=1, B=1, N=17, W=16 -> out_valid exactly 52 cycles after handshake, m_o=1.
//  3. A=B=2^272-1 -> m_o = 2^544-2^273+1; exercises full carry ripple and max column sums.
//  4. sq_i=1, A=0x1_0000_0003, B=random -> m_o = A*A; B ignored.
//  5. out_ready low 10 cycles in DONE -> m_o stable, in_ready=0, new in_valid ignored; then accepted after release.
//  6. Reset asserted during MUL, then new op, plus 300 random back-to-back ops -> all m_o equal a_i*b_i, zero mismatches.

Source files
------------

// File: rtl/multiplier_pkg.sv
// Shared definitions for the limb-serial multiplier.
// Contents:
//   mul_state_t   FSM encoding {IDLE, MUL, NORM, DONE}
//   acc_len()     accumulator column width: 2*w + clog2(n) + 1
//   limb_lsb()    bit offset of limb idx in a packed limb vector
package multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } mul_state_t;

    // A column sums at most n products below 2^(2w), so 2w + clog2(n) bits
    // suffice; the extra bit leaves room for the incoming ripple carry.
    function automatic int acc_len(input int n, input int w);
        return 2 * w + $clog2(n) + 1;
    endfunction

    // Limb idx of a packed vector occupies [w*(idx+1)-1 : w*idx].
    function automatic int limb_lsb(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/multiplier_seq_if.sv
// Handshake bundle for multiplier_seq.
// Handshake rule (both directions): a transfer happens on a rising clk edge
// where valid && ready are both high. The producer holds its payload stable
// while valid && !ready; the consumer may raise or drop ready at any time.
//   in_valid/in_ready   operand transfer (sq_i, a_i, b_i)
//   out_valid/out_ready product transfer (m_o)
//   busy_o              high while multiplying or normalising
//   state_o             current FSM state, for observation only
interface multiplier_seq_if
    import multiplier_pkg::*;
#(
    parameter int NUM_ELEMENTS = 17,
    parameter int WORD_LEN     = 16
);
    logic                               in_valid;
    logic                               in_ready;
    logic                               sq_i;
    logic [NUM_ELEMENTS*WORD_LEN-1:0]   a_i;
    logic [NUM_ELEMENTS*WORD_LEN-1:0]   b_i;
    logic                               out_valid;
    logic                               out_ready;
    logic [2*NUM_ELEMENTS*WORD_LEN-1:0] m_o;
    logic                               busy_o;
    mul_state_t                         state_o;

    modport master (
        output in_valid, sq_i, a_i, b_i, out_ready,
        input  in_ready, out_valid, m_o, busy_o, state_o
    );

    modport slave (
        input  in_valid, sq_i, a_i, b_i, out_ready,
        output in_ready, out_valid, m_o, busy_o, state_o
    );
endinterface

// File: rtl/multiplier_row.sv
// One limb-row of multipliers: every A limb times a single B limb.
// Ports:
//   a_limbs  in   NUM_ELEMENTS*WORD_LEN    all A limbs, packed
//   b_limb   in   WORD_LEN                 the B limb of the current row
//   pp       out  NUM_ELEMENTS*2*WORD_LEN  partial product i at [2W*(i+1)-1 : 2W*i]
module multiplier_row
    import multiplier_pkg::*;
#(
    parameter int NUM_ELEMENTS = 17,
    parameter int WORD_LEN     = 16
) (
    input  logic [NUM_ELEMENTS*WORD_LEN-1:0]   a_limbs,
    input  logic [WORD_LEN-1:0]                b_limb,
    output logic [NUM_ELEMENTS*2*WORD_LEN-1:0] pp
);
    always_comb begin
        pp = '0;
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            pp[limb_lsb(i, 2*WORD_LEN) +: 2*WORD_LEN] =
                a_limbs[limb_lsb(i, WORD_LEN) +: WORD_LEN] * b_limb;
        end
    end
endmodule

// File: rtl/multiplier_seq.sv
// Limb-serial multi-precision unsigned multiplier: M = A*B, or A*A when sq_i.
// One B limb per cycle is multiplied against all A limbs and added into
// 2*NUM_ELEMENTS accumulator columns (MUL), then a ripple pass turns the
// columns into a fully normalised packed product (NORM). Latency is fixed
// at 3*NUM_ELEMENTS+1 cycles from the operand handshake.
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset, aborts any operation
//   bus    slave modport of multiplier_seq_if (handshakes, operands, product)
module multiplier_seq
    import multiplier_pkg::*;
#(
    parameter int NUM_ELEMENTS = 17,
    parameter int WORD_LEN     = 16
) (
    input logic              clk,
    input logic              rst_n,
    multiplier_seq_if.slave  bus
);
    localparam int N       = NUM_ELEMENTS;
    localparam int W       = WORD_LEN;
    localparam int ACC_LEN = acc_len(N, W);
    localparam int CW      = ACC_LEN - W;
    localparam int KW      = $clog2(N);
    localparam int JW      = $clog2(2 * N);

    mul_state_t           state;
    logic [N*W-1:0]       a_q;
    logic [N*W-1:0]       b_q;
    logic [ACC_LEN-1:0]   acc [2*N];
    logic [CW-1:0]        carry;
    logic [KW-1:0]        k;
    logic [JW-1:0]        j;
    logic [2*N*W-1:0]     m_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 busy_q;
    logic [N*2*W-1:0]     pp;
    logic [ACC_LEN-1:0]   norm_sum;

    multiplier_row #(
        .NUM_ELEMENTS (N),
        .WORD_LEN     (W)
    ) u_row (
        .a_limbs (a_q),
        .b_limb  (b_q[limb_lsb(int'(k), W) +: W]),
        .pp      (pp)
    );

    // The carry is always narrower than a column, so this cannot overflow.
    assign norm_sum = acc[j] + ACC_LEN'(carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            m_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry       <= '0;
            k           <= '0;
            j           <= '0;
            for (int c = 0; c < 2 * N; c++) acc[c] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is high throughout IDLE, so in_valid alone
                    // completes the handshake here.
                    if (bus.in_valid) begin
                        a_q        <= bus.a_i;
                        b_q        <= bus.sq_i ? bus.a_i : bus.b_i;
                        for (int c = 0; c < 2 * N; c++) acc[c] <= '0;
                        k          <= '0;
                        j          <= '0;
                        carry      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= MUL;
                    end
                end
                MUL: begin
                    // Row k lands in columns k .. k+N-1.
                    for (int i = 0; i < N; i++) begin
                        acc[JW'(k) + JW'(i)] <= acc[JW'(k) + JW'(i)]
                            + ACC_LEN'(pp[limb_lsb(i, 2*W) +: 2*W]);
                    end
                    if (k == KW'(N - 1)) begin
                        j     <= '0;
                        carry <= '0;
                        state <= NORM;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                NORM: begin
                    m_q[limb_lsb(int'(j), W) +: W] <= norm_sum[W-1:0];
                    carry <= norm_sum[ACC_LEN-1:W];
                    if (j == JW'(2 * N - 1)) begin
                        // The product fits in 2N limbs, so nothing may carry out.
                        assert (norm_sum[ACC_LEN-1:W] == '0);
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy_o    = busy_q;
    assign bus.m_o       = m_q;
    assign bus.state_o   = state;
endmodule

// File: tb/tb_multiplier_seq.sv
module tb_multiplier_seq;
    import multiplier_pkg::*;

    localparam int N  = 17;
    localparam int W  = 16;
    localparam int NW = N * W;
    localparam int MW = 2 * N * W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    multiplier_seq_if #(.NUM_ELEMENTS(N), .WORD_LEN(W)) bus ();

    multiplier_seq #(.NUM_ELEMENTS(N), .WORD_LEN(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ---------------- scoreboard ----------------
    logic [MW-1:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    int unsigned hs_cyc = 0;

    task automatic check(input string name, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: pops one expected product for every output transfer.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL result_unexpected: got %h expected no output", bus.m_o);
            end else begin
                check("result", bus.m_o, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [NW-1:0] rand_op();
        logic [NW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom_range(0, 65535));
        return v;
    endfunction

    // Present operands and hold until accepted; expected product is queued
    // in the cycle the handshake happens. Returns just after that edge.
    task automatic send(input logic [NW-1:0] a, input logic [NW-1:0] b,
                        input logic sq, input logic [MW-1:0] exp);
        bit done;
        done = 0;
        @(posedge clk); #2;
        bus.in_valid = 1'b1;
        bus.a_i = a;
        bus.b_i = b;
        bus.sq_i = sq;
        for (int t = 0; t < 500 && !done; t++) begin
            if (bus.in_ready) begin
                hs_cyc = cyc;
                exp_q.push_back(exp);
                done = 1;
            end
            @(posedge clk); #2;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout: in_ready got 0 expected 1");
        end
        // Operands must be sampled only at the handshake.
        bus.in_valid = 1'b0;
        bus.a_i = rand_op();
        bus.b_i = rand_op();
        bus.sq_i = 1'b0;
    endtask

    task automatic wait_out_valid(output bit ok);
        ok = 0;
        for (int t = 0; t < 500 && !ok; t++) begin
            @(negedge clk);
            if (bus.out_valid) ok = 1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL out_valid_timeout: got 0 expected 1");
        end
    endtask

    task automatic drain();
        bit empty;
        empty = 0;
        for (int t = 0; t < 3000 && !empty; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0) empty = 1;
        end
        checks++;
        if (!empty) begin
            failures++;
            $display("FAIL drain: pending got %0d expected 0", exp_q.size());
        end
    endtask

    // ---------------- stimulus ----------------
    logic [NW-1:0] one_v, ones_v, sq_a, a1, b1, ra, rb;
    logic [MW-1:0] e_max, e_sq, e_p1, prod;
    bit ok;
    bit rs;

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.sq_i = 1'b0;
        bus.a_i = '0;
        bus.b_i = '0;

        one_v  = NW'(1);
        ones_v = '1;
        sq_a   = NW'(68'h1_0000_0003);
        e_sq   = MW'(132'h1_0000_0006_0000_0009);
        // (2^272-1)^2 = 2^544 - 2^273 + 1, computed modulo 2^544
        e_max  = '1;
        e_max  = e_max - (MW'(1) << 273) + MW'(2);
        // 0x1234 * 0x10001 spread over limbs 0 and 16, times 7 in limb 1
        a1 = '0;
        a1[15:0] = 16'h1234;
        a1[271:256] = 16'h0001;
        b1 = '0;
        b1[31:16] = 16'h0007;
        e_p1 = '0;
        e_p1[31:16] = 16'h7F6C;     // 0x1234*7 = 0x7F6C
        e_p1[287:272] = 16'h0007;   // 2^256 * 7 * 2^16

        // Reset state
        #12;
        check("rst_in_ready", MW'(bus.in_ready), MW'(1));
        check("rst_out_valid", MW'(bus.out_valid), MW'(0));
        check("rst_busy", MW'(bus.busy_o), MW'(0));
        check("rst_m_o", bus.m_o, '0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // A=1, B=1: latency and value
        send(one_v, one_v, 1'b0, MW'(1));
        wait_out_valid(ok);
        if (ok) check("latency", MW'(cyc - hs_cyc), MW'(52));
        drain();

        // All-ones operands: full carry ripple
        send(ones_v, ones_v, 1'b0, e_max);
        drain();

        // Square mode ignores B
        send(sq_a, rand_op(), 1'b1, e_sq);
        drain();

        // Zero operands
        send('0, rand_op(), 1'b0, '0);
        send(rand_op(), '0, 1'b0, '0);
        send(a1, b1, 1'b0, e_p1);
        drain();

        // Back-pressure: product held, new operands ignored
        bus.out_ready = 1'b0;
        send(ones_v, ones_v, 1'b0, e_max);
        wait_out_valid(ok);
        @(posedge clk); #2;
        bus.in_valid = 1'b1;
        bus.a_i = one_v;
        bus.b_i = one_v;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            check("stall_m_o", bus.m_o, e_max);
            check("stall_in_ready", MW'(bus.in_ready), MW'(0));
            check("stall_out_valid", MW'(bus.out_valid), MW'(1));
        end
        @(posedge clk); #2;
        bus.out_ready = 1'b1;
        send(one_v, one_v, 1'b0, MW'(1));
        drain();

        // Reset during MUL, checked asynchronously before any clock edge
        send(ones_v, ones_v, 1'b0, e_max);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", MW'(bus.in_ready), MW'(1));
        check("midrst_out_valid", MW'(bus.out_valid), MW'(0));
        check("midrst_busy", MW'(bus.busy_o), MW'(0));
        check("midrst_m_o", bus.m_o, '0);
        exp_q.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        send(sq_a, one_v, 1'b1, e_sq);
        drain();

        // Back-to-back random operations
        for (int n = 0; n < 300; n++) begin
            ra = rand_op();
            rb = rand_op();
            rs = ($urandom_range(0, 9) == 0);
            if (rs) prod = MW'(ra) * MW'(ra);
            else    prod = MW'(ra) * MW'(rb);
            send(ra, rb, rs, prod);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
